result_line_packer: RTL and testbench
=====================================

# result_line_packer

Downstream neighbour of the compute engine's result port. Accepts one FP16 result per cycle and packs 16 consecutive results into a 256-bit line. Buffers lines in a small show-ahead FIFO and presents them on a valid/ready stream to the result writeback path. Drives the engine's full/almost-full inputs, and emits a zero-padded partial line when flushed at tile end.

## Interface
- `LINE_DEPTH`, default 8: line FIFO depth, power of 2, ≥4.
- `AFULL_MARGIN`, default 2: free-line threshold for almost-full.
- `i_clk`  in  1: clock, all logic on rising edge.
- `i_reset_n`  in  1: reset, asynchronous and active-low.
- `i_clear`  in  1: synchronous clear of pack register, FIFO, flags and stats.
- `i_result_data`  in  16: FP16 result.
- `i_result_valid`  in  1: result strobe; no ready, a result is sampled whenever high.
- `o_result_full`  out  1: next result would be dropped.
- `o_result_afull`  out  1: `fifo_count >= LINE_DEPTH-AFULL_MARGIN`.
- `i_flush`  in  1: one-cycle pulse, close current partial line (driven by tile done).
- `o_flush_done`  out  1: one-cycle pulse when flush has completed.
- `o_line_data`  out  256: packed line; element k occupies bits [16k+15:16k], first-received element is k=0.
- `o_line_nelem`  out  5: valid elements in line, 1..16.
- `o_line_valid`  out  1: FIFO head valid.
- `i_line_ready`  in  1: consumer accept; pop on `valid&&ready`.
- `o_overflow`  out  1: sticky, a result was dropped.
- `o_fifo_count`  out  `$clog2(LINE_DEPTH)+1`: lines held.
- `o_lines_out`  out  16: lines popped (stats).
- `o_drop_count`  out  16: results dropped (stats).

## Operation
- Pack FSM `pk_state`, three states:
  - PK_EMPTY: `pack_cnt==0`.
  - PK_FILL: `1..15` elements held.
  - PK_FLUSH_WAIT: flush pending, FIFO full.
- An accepted result writes lane `pack_cnt`, then `pack_cnt++`.
- Completing the 16th lane pushes the line (`nelem=16`) to the FIFO on the same edge. `pack_cnt` returns to 0 and the state goes to PK_EMPTY.
- Push while FIFO full is impossible for a completed line. `o_result_full = (fifo_count==LINE_DEPTH && pack_cnt==15) || pk_state==PK_FLUSH_WAIT`.
- A result arriving while `o_result_full` is high:
  - it is dropped, `o_overflow` is set and `drop_count++`;
  - exception: a pop in the same cycle frees a slot and the result is accepted.
- Flush handling:
  - Flush in PK_EMPTY: no line pushed; `o_flush_done` pulses the next cycle.
  - Flush in PK_FILL with space: push the line with unused lanes zeroed and `nelem=pack_cnt`; go to PK_EMPTY; `o_flush_done` pulses the next cycle.
  - Flush with FIFO full: enter PK_FLUSH_WAIT; push on the first cycle a slot is free (including the pop cycle); pulse `o_flush_done` after that push.
- Simultaneous result and flush: the result is packed first, then the flush applies to the updated line. If that result completes 16, only the full line is pushed, with no extra empty line.
- Flush pulse while already in PK_FLUSH_WAIT is ignored.
- Simultaneous push and pop: count unchanged, data ordering preserved.
- `i_clear` takes priority over all events in its cycle.

## Timing
- Reset or clear sets every output to 0, and sets `pk_state=PK_EMPTY`.
- Latency from the edge sampling the 16th result (or the flush) to `o_line_valid` high is 1 cycle.
- `o_line_data` and `o_line_nelem` are stable while `o_line_valid && !i_line_ready`.
- `o_result_full`, `o_result_afull` and `o_fifo_count` are combinational from registered state; there is no path from `i_line_ready` to `o_result_full`.
- Throughput: 1 result per cycle sustained while the consumer accepts ≥1 line per 16 cycles.
- Reset mid-line discards the partial line; no `o_flush_done` is generated.

## Configuration
- `RESULT_PACKER_STATS_EN` defined:
  - `o_lines_out` and `o_drop_count` are live 16-bit counters;
  - they saturate at 0xFFFF and clear on reset or `i_clear`.
- Undefined: both ports are tied to 0 and no counter flops are built. `o_overflow` exists in both builds.

## Structure
- Shared `gemm_pkg` additions:
  - `FP16_W=16`, `PACK_LANES=16`, `LINE_W=256`;
  - enum `pk_state_t` {PK_EMPTY, PK_FILL, PK_FLUSH_WAIT};
  - packed struct `result_line_t` {`nelem[4:0]`, `data[255:0]`}.
- One sub-module, `result_line_fifo`: a show-ahead synchronous FIFO of `result_line_t`, with count output.

## Test plan
- 32 results 0x3C00+i back-to-back, `i_line_ready=1`:
  - two lines, 1 cycle after each 16th result;
  - line0 bits[15:0]=0x3C00, bits[255:240]=0x3C0F; `nelem=16`.
- 5 results, then `i_flush`: one line with `nelem=5`, lanes 5..15 = 0; `o_flush_done` 1 cycle later.
- Result #16 and `i_flush` in the same cycle: exactly one line (`nelem=16`); `o_flush_done` pulses.
- `i_line_ready=0`, `LINE_DEPTH=8`:
  - `o_result_afull` at `fifo_count=6`;
  - `o_result_full` once 8 lines are held plus 15 elements;
  - a 144th result is dropped and `o_overflow=1`; with the macro, `drop_count=1`.
- FIFO full, 3 elements packed, flush: FSM goes to PK_FLUSH_WAIT. Raise ready for 1 cycle: partial line pushed that cycle, then `o_flush_done`.
- Assert `i_reset_n` low mid-line with 3 lines queued: all outputs 0; the next 16 results form a clean line0.

Source files
------------

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types and widths for the result line packer
package gemm_pkg;

  localparam int FP16_W     = 16;
  localparam int PACK_LANES = 16;
  localparam int LINE_W     = 256;

  typedef enum logic [1:0] {
    PK_EMPTY      = 2'd0,
    PK_FILL       = 2'd1,
    PK_FLUSH_WAIT = 2'd2
  } pk_state_t;

  typedef struct packed {
    logic [4:0]        nelem;
    logic [LINE_W-1:0] data;
  } result_line_t;

  // Return a copy of line with lane 'lane' replaced by val.
  function automatic logic [LINE_W-1:0] lane_insert(input logic [LINE_W-1:0] line,
                                                    input logic [3:0]        lane,
                                                    input logic [FP16_W-1:0] val);
    logic [LINE_W-1:0] r;
    r = line;
    r[lane*FP16_W +: FP16_W] = val;
    return r;
  endfunction

endpackage

// File: rtl/result_line_fifo.sv
// rtl/result_line_fifo.sv - show-ahead synchronous FIFO of result lines with occupancy count
module result_line_fifo
  import gemm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  result_line_t           i_push_line,
  input  logic                   i_pop,
  output result_line_t           o_head,
  output logic                   o_head_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  result_line_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_pop;
  logic           do_push;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = i_pop && (count_q != '0);
  assign do_push = i_push && ((count_q != FULL_CNT) || do_pop);

  // Line storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_push_line;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_head_valid = (count_q != '0);
  assign o_head       = o_head_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count      = count_q;

endmodule

// File: rtl/result_line_packer.sv
// rtl/result_line_packer.sv - packs FP16 results into 256-bit lines; RESULT_PACKER_STATS_EN enables line/drop counters
module result_line_packer
  import gemm_pkg::*;
#(
  parameter int LINE_DEPTH   = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_clear,
  input  logic [15:0]                 i_result_data,
  input  logic                        i_result_valid,
  output logic                        o_result_full,
  output logic                        o_result_afull,
  input  logic                        i_flush,
  output logic                        o_flush_done,
  output logic [255:0]                o_line_data,
  output logic [4:0]                  o_line_nelem,
  output logic                        o_line_valid,
  input  logic                        i_line_ready,
  output logic                        o_overflow,
  output logic [$clog2(LINE_DEPTH):0] o_fifo_count,
  output logic [15:0]                 o_lines_out,
  output logic [15:0]                 o_drop_count
);

  localparam int CW = $clog2(LINE_DEPTH) + 1;

  pk_state_t         pk_state_q, pk_state_d;
  logic [3:0]        pack_cnt_q, pack_cnt_d;
  logic [LINE_W-1:0] lanes_q, lanes_d;
  logic              overflow_q, overflow_d;
  logic              flush_done_q, flush_done_d;

  logic [LINE_W-1:0] lanes_n;
  logic [4:0]        nelem_n;
  logic              push;
  result_line_t      push_line;
  logic              pop;
  result_line_t      head;
  logic              head_valid;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              result_full;
  logic              accept;
  logic              drop;

  result_line_fifo #(.DEPTH(LINE_DEPTH)) u_fifo (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (i_clear),
    .i_push       (push),
    .i_push_line  (push_line),
    .i_pop        (pop),
    .o_head       (head),
    .o_head_valid (head_valid),
    .o_count      (fifo_count)
  );

  assign fifo_full   = (fifo_count == CW'(LINE_DEPTH));
  assign pop         = head_valid && i_line_ready;
  // Full is derived from registered state only; a same-cycle pop rescues the result separately.
  assign result_full = (fifo_full && (pack_cnt_q == 4'd15)) || (pk_state_q == PK_FLUSH_WAIT);
  assign accept      = i_result_valid && (!result_full || pop);
  assign drop        = i_result_valid && !accept;

  // Next-state for the pack register: result first, then line completion, then flush.
  always_comb begin
    pk_state_d   = pk_state_q;
    pack_cnt_d   = pack_cnt_q;
    lanes_d      = lanes_q;
    overflow_d   = overflow_q | drop;
    flush_done_d = 1'b0;
    push         = 1'b0;
    push_line    = '0;
    lanes_n      = lanes_q;
    nelem_n      = {1'b0, pack_cnt_q};

    if (pk_state_q == PK_FLUSH_WAIT) begin
      // Closed partial line leaves as soon as a slot opens; a result accepted
      // on that edge starts the next line rather than joining the closed one.
      if (pop) begin
        push            = 1'b1;
        push_line.nelem = {1'b0, pack_cnt_q};
        push_line.data  = lanes_q;
        flush_done_d    = 1'b1;
        if (accept) begin
          lanes_d    = lane_insert('0, 4'd0, i_result_data);
          pack_cnt_d = 4'd1;
          pk_state_d = PK_FILL;
        end else begin
          lanes_d    = '0;
          pack_cnt_d = 4'd0;
          pk_state_d = PK_EMPTY;
        end
      end
    end else begin
      if (accept) begin
        lanes_n = lane_insert(lanes_q, pack_cnt_q, i_result_data);
        nelem_n = {1'b0, pack_cnt_q} + 5'd1;
      end

      if (nelem_n == 5'd16) begin
        // Completed line; a coincident flush has nothing left to close.
        push            = 1'b1;
        push_line.nelem = 5'd16;
        push_line.data  = lanes_n;
        lanes_d         = '0;
        pack_cnt_d      = 4'd0;
        pk_state_d      = PK_EMPTY;
        flush_done_d    = i_flush;
      end else if (i_flush) begin
        if (nelem_n == 5'd0) begin
          flush_done_d = 1'b1;
          pk_state_d   = PK_EMPTY;
        end else if (!fifo_full || pop) begin
          // Unused lanes are already zero because the register clears on every push.
          push            = 1'b1;
          push_line.nelem = nelem_n;
          push_line.data  = lanes_n;
          lanes_d         = '0;
          pack_cnt_d      = 4'd0;
          pk_state_d      = PK_EMPTY;
          flush_done_d    = 1'b1;
        end else begin
          lanes_d    = lanes_n;
          pack_cnt_d = nelem_n[3:0];
          pk_state_d = PK_FLUSH_WAIT;
        end
      end else begin
        lanes_d    = lanes_n;
        pack_cnt_d = nelem_n[3:0];
        pk_state_d = (nelem_n == 5'd0) ? PK_EMPTY : PK_FILL;
      end
    end
  end

  // Pack register, FSM and flags; clear wins over every other event.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pk_state_q   <= PK_EMPTY;
      pack_cnt_q   <= '0;
      lanes_q      <= '0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else if (i_clear) begin
      pk_state_q   <= PK_EMPTY;
      pack_cnt_q   <= '0;
      lanes_q      <= '0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      pk_state_q   <= pk_state_d;
      pack_cnt_q   <= pack_cnt_d;
      lanes_q      <= lanes_d;
      overflow_q   <= overflow_d;
      flush_done_q <= flush_done_d;
    end
  end

`ifdef RESULT_PACKER_STATS_EN
  logic [15:0] lines_out_q;
  logic [15:0] drop_cnt_q;

  // Saturating counters of popped lines and dropped results.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lines_out_q <= '0;
      drop_cnt_q  <= '0;
    end else if (i_clear) begin
      lines_out_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (pop && (lines_out_q != 16'hFFFF)) lines_out_q <= lines_out_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_lines_out  = lines_out_q;
  assign o_drop_count = drop_cnt_q;
`else
  assign o_lines_out  = 16'd0;
  assign o_drop_count = 16'd0;
`endif

  assign o_result_full  = result_full;
  assign o_result_afull = (int'(fifo_count) >= (LINE_DEPTH - AFULL_MARGIN));
  assign o_fifo_count   = fifo_count;
  assign o_flush_done   = flush_done_q;
  assign o_overflow     = overflow_q;
  assign o_line_valid   = head_valid;
  assign o_line_data    = head.data;
  assign o_line_nelem   = head.nelem;

endmodule

// File: tb/tb_result_line_packer.sv
// tb/tb_result_line_packer.sv - directed table-driven bench for result_line_packer
module tb_result_line_packer;
  import gemm_pkg::*;

`ifdef RESULT_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [15:0]  result_data;
  logic         result_valid;
  logic         result_full;
  logic         result_afull;
  logic         flush;
  logic         flush_done;
  logic [255:0] line_data;
  logic [4:0]   line_nelem;
  logic         line_valid;
  logic         line_ready;
  logic         overflow;
  logic [3:0]   fifo_count;
  logic [15:0]  lines_out;
  logic [15:0]  drop_count;

  int n_cmp;
  int n_bad;

  result_line_packer #(.LINE_DEPTH(8), .AFULL_MARGIN(2)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_clear        (clear),
    .i_result_data  (result_data),
    .i_result_valid (result_valid),
    .o_result_full  (result_full),
    .o_result_afull (result_afull),
    .i_flush        (flush),
    .o_flush_done   (flush_done),
    .o_line_data    (line_data),
    .o_line_nelem   (line_nelem),
    .o_line_valid   (line_valid),
    .i_line_ready   (line_ready),
    .o_overflow     (overflow),
    .o_fifo_count   (fifo_count),
    .o_lines_out    (lines_out),
    .o_drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [15:0]  d;
    logic         fl;
    logic         rdy;
    logic         e_valid;
    logic [4:0]   e_nelem;
    logic [255:0] e_data;
    logic [3:0]   e_count;
    logic         e_fdone;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, return 1 ns after the edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic fl, input logic rdy);
    result_valid = v;
    result_data  = d;
    flush        = fl;
    line_ready   = rdy;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    flush        = 1'b0;
  endtask

  function automatic logic [255:0] mk_line(input int base, input int n);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*16 +: 16] = 16'(base + k);
    return r;
  endfunction

  function automatic vec_t mkv(input logic v, input logic [15:0] d, input logic fl, input logic rdy,
                               input logic ev, input logic [4:0] en, input logic [255:0] ed,
                               input logic [3:0] ec, input logic ef);
    vec_t r;
    r.v = v; r.d = d; r.fl = fl; r.rdy = rdy;
    r.e_valid = ev; r.e_nelem = en; r.e_data = ed; r.e_count = ec; r.e_fdone = ef;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  256'(line_valid),   256'(0));
    chk({tag, "_data"},   line_data,          256'(0));
    chk({tag, "_nelem"},  256'(line_nelem),   256'(0));
    chk({tag, "_count"},  256'(fifo_count),   256'(0));
    chk({tag, "_full"},   256'(result_full),  256'(0));
    chk({tag, "_afull"},  256'(result_afull), 256'(0));
    chk({tag, "_fdone"},  256'(flush_done),   256'(0));
    chk({tag, "_ovf"},    256'(overflow),     256'(0));
    chk({tag, "_lines"},  256'(lines_out),    256'(0));
    chk({tag, "_drops"},  256'(drop_count),   256'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    result_data  = '0;
    result_valid = 1'b0;
    flush        = 1'b0;
    line_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // 32 back-to-back results, consumer always ready
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 16'(16'h3C00 + i), 1'b0, 1'b1);
      chk("t1_valid", 256'(line_valid), 256'(i == 15 || i == 31));
      if (i == 15) begin
        chk("t1_nelem", 256'(line_nelem), 256'(16));
        chk("t1_lane0", 256'(line_data[15:0]), 256'(16'h3C00));
        chk("t1_lane15", 256'(line_data[255:240]), 256'(16'h3C0F));
      end
      if (i == 31) chk("t1_line1", line_data, mk_line(16'h3C10, 16));
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t1_drained", 256'(line_valid), 256'(0));
    chk("t1_lines_out", 256'(lines_out), STATS ? 256'(2) : 256'(0));

    // Table: partial flush, 16th result coincident with flush, flush while empty
    for (int k = 0; k < 5; k++)
      tab.push_back(mkv(1'b1, 16'(16'h1000 + k), 1'b0, 1'b1, 1'b0, 5'd0, '0, 4'd0, 1'b0));
    tab.push_back(mkv(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 5'd5, mk_line(16'h1000, 5), 4'd1, 1'b1));
    tab.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 4'd0, 1'b0));
    for (int k = 0; k < 15; k++)
      tab.push_back(mkv(1'b1, 16'(16'h2000 + k), 1'b0, 1'b1, 1'b0, 5'd0, '0, 4'd0, 1'b0));
    tab.push_back(mkv(1'b1, 16'h200F, 1'b1, 1'b1, 1'b1, 5'd16, mk_line(16'h2000, 16), 4'd1, 1'b1));
    tab.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 4'd0, 1'b0));
    tab.push_back(mkv(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 5'd0, '0, 4'd0, 1'b1));
    tab.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 4'd0, 1'b0));
    foreach (tab[r]) begin
      cyc(tab[r].v, tab[r].d, tab[r].fl, tab[r].rdy);
      chk($sformatf("tab%0d_valid", r), 256'(line_valid), 256'(tab[r].e_valid));
      chk($sformatf("tab%0d_count", r), 256'(fifo_count), 256'(tab[r].e_count));
      chk($sformatf("tab%0d_fdone", r), 256'(flush_done), 256'(tab[r].e_fdone));
      if (tab[r].e_valid) begin
        chk($sformatf("tab%0d_nelem", r), 256'(line_nelem), 256'(tab[r].e_nelem));
        chk($sformatf("tab%0d_data", r), line_data, tab[r].e_data);
      end
    end

    // Back-pressure: almost-full, full and a dropped 144th result
    for (int j = 0; j < 143; j++) begin
      cyc(1'b1, 16'(j), 1'b0, 1'b0);
      if (j == 94)  chk("bp_afull_5", 256'(result_afull), 256'(0));
      if (j == 95) begin
        chk("bp_afull_6", 256'(result_afull), 256'(1));
        chk("bp_count_6", 256'(fifo_count), 256'(6));
      end
      if (j == 141) chk("bp_full_14", 256'(result_full), 256'(0));
      if (j == 142) begin
        chk("bp_full_15", 256'(result_full), 256'(1));
        chk("bp_count_8", 256'(fifo_count), 256'(8));
        chk("bp_ovf_pre", 256'(overflow), 256'(0));
      end
    end
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("bp_overflow", 256'(overflow), 256'(1));
    chk("bp_drops", 256'(drop_count), STATS ? 256'(1) : 256'(0));
    chk("bp_count_held", 256'(fifo_count), 256'(8));
    clear = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    clear = 1'b0;
    chk_all_zero("clear");

    // Flush with FIFO full: wait state, single ready cycle releases it
    for (int j = 0; j < 131; j++) cyc(1'b1, 16'(j), 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fw_state", 256'(dut.pk_state_q), 256'(PK_FLUSH_WAIT));
    chk("fw_full", 256'(result_full), 256'(1));
    chk("fw_fdone0", 256'(flush_done), 256'(0));
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fw_ignored_fdone", 256'(flush_done), 256'(0));
    chk("fw_ignored_count", 256'(fifo_count), 256'(8));
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("fw_fdone1", 256'(flush_done), 256'(1));
    chk("fw_count", 256'(fifo_count), 256'(8));
    chk("fw_full_rel", 256'(result_full), 256'(0));
    chk("fw_head1", line_data, mk_line(16, 16));
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      chk("fw_fdone_off", 256'(flush_done), 256'(0));
      if (k < 7) begin
        chk("fw_drain_nelem", 256'(line_nelem), 256'(16));
        chk("fw_drain_data", line_data, mk_line(16 * (1 + k), 16));
      end else begin
        chk("fw_part_nelem", 256'(line_nelem), 256'(3));
        chk("fw_part_data", line_data, mk_line(128, 3));
      end
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("fw_empty", 256'(line_valid), 256'(0));

    // Asynchronous reset mid-line with three lines queued
    for (int j = 0; j < 53; j++) cyc(1'b1, 16'(16'h4000 + j), 1'b0, 1'b0);
    chk("rst_pre_count", 256'(fifo_count), 256'(3));
    rst_n = 1'b0;
    #2;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 16; j++) cyc(1'b1, 16'(16'h5000 + j), 1'b0, 1'b0);
    chk("rst_line_valid", 256'(line_valid), 256'(1));
    chk("rst_line_count", 256'(fifo_count), 256'(1));
    chk("rst_line_nelem", 256'(line_nelem), 256'(16));
    chk("rst_line_data", line_data, mk_line(16'h5000, 16));
    chk("rst_fdone", 256'(flush_done), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
